// File: rtl/cm0_rst_req_gen_if.sv
// Reset request sources in, registered reset request and sticky cause out.
interface cm0_rst_req_gen_if;
    logic       SYSRESETREQ;
    logic       WDOGRESREQ;
    logic       LOCKUP;
    logic       LOCKUPRESET;
    logic       CAUSECLR;
    logic       RSTREQ;
    logic       RSTBUSY;
    logic [3:0] RSTCAUSE;

    modport master (
        output SYSRESETREQ, WDOGRESREQ, LOCKUP, LOCKUPRESET, CAUSECLR,
        input  RSTREQ, RSTBUSY, RSTCAUSE
    );

    modport slave (
        input  SYSRESETREQ, WDOGRESREQ, LOCKUP, LOCKUPRESET, CAUSECLR,
        output RSTREQ, RSTBUSY, RSTCAUSE
    );
endinterface

// File: rtl/cm0_rst_req_gen.sv
// Merges core/watchdog/lockup reset requests into one minimum-width, glitch-free
// RSTREQ pulse with a guard hold-off, and keeps a sticky reset cause.
module cm0_rst_req_gen #(
    parameter int unsigned PULSE_CYCLES = 4,
    parameter int unsigned GUARD_CYCLES = 8
) (
    input  logic              CLK,
    input  logic              RST,
    cm0_rst_req_gen_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ASSERT, HOLD, GUARD} state_t;

    localparam logic [7:0] PULSE_LD  = 8'(PULSE_CYCLES - 1);
    localparam logic [7:0] GUARD_LD  = (GUARD_CYCLES == 0) ? 8'd0 : 8'(GUARD_CYCLES - 1);
    localparam bit         HAS_GUARD = (GUARD_CYCLES != 0);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       rstreq_q, rstreq_d;
    logic [3:0] cause_q, cause_d;
    logic [2:0] src;
    logic       req;
    logic       take;
    logic       drop;

    assign src = {bus.LOCKUP & bus.LOCKUPRESET, bus.WDOGRESREQ, bus.SYSRESETREQ};
    assign req = |src;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            rstreq_q <= 1'b0;
            cause_q  <= 4'b1000;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rstreq_q <= rstreq_d;
            cause_q  <= cause_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rstreq_d = rstreq_q;
        take     = 1'b0;
        drop     = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d  = ASSERT;
                    cnt_d    = PULSE_LD;
                    rstreq_d = 1'b1;
                    take     = 1'b1;
                end
            end
            ASSERT: begin
                if (cnt_q != 8'd0)  cnt_d   = cnt_q - 8'd1;
                else if (req)       state_d = HOLD;
                else                drop    = 1'b1;
            end
            HOLD: begin
                if (!req) drop = 1'b1;
            end
            GUARD: begin
                // Requests are not latched here; a level still high is taken from IDLE.
                if (cnt_q != 8'd0) cnt_d   = cnt_q - 8'd1;
                else               state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (drop) begin
            rstreq_d = 1'b0;
            if (HAS_GUARD) begin
                state_d = GUARD;
                cnt_d   = GUARD_LD;
            end else begin
                state_d = IDLE;
            end
        end

        // A clear and a new event on the same edge: the new cause bits survive.
        cause_d = (bus.CAUSECLR ? 4'b0000 : cause_q) | {1'b0, take ? src : 3'b000};
    end

    assign bus.RSTREQ   = rstreq_q;
    assign bus.RSTBUSY  = (state_q != IDLE);
    assign bus.RSTCAUSE = cause_q;
endmodule

// File: tb/tb_cm0_rst_req_gen.sv
// Bench for cm0_rst_req_gen: directed reset/lockup/clear cases, then random
// request waveforms scored pulse-by-pulse against a timeline model.
module tb_cm0_rst_req_gen;
  localparam int P    = 4;
  localparam int G    = 8;
  localparam int T    = 840;
  localparam int TAIL = 40;

  typedef struct {
    int         start;
    int         width;
    int         guard;
    logic [3:0] cause;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  cm0_rst_req_gen_if bus();

  cm0_rst_req_gen #(.PULSE_CYCLES(P), .GUARD_CYCLES(G)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int   checks   = 0;
  int   failures = 0;
  int   edge_cnt = 0;
  bit   mon_en   = 1'b0;
  exp_t exp_q[$];

  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string nm, input int act, input int req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req_v);
    end
  endtask

  task automatic drive(input logic [4:0] s);
    bus.SYSRESETREQ = s[0];
    bus.WDOGRESREQ  = s[1];
    bus.LOCKUP      = s[2];
    bus.LOCKUPRESET = s[3];
    bus.CAUSECLR    = s[4];
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  // Monitor: measures each RSTREQ pulse and the busy tail that follows it.
  bit         in_pulse = 1'b0;
  bit         in_guard = 1'b0;
  int         m_start, m_w, m_g;
  logic [3:0] m_cause;
  exp_t       e_mon;

  always @(negedge CLK) begin
    if (RST || !mon_en) begin
      in_pulse = 1'b0;
      in_guard = 1'b0;
    end else begin
      if (in_pulse && !bus.RSTREQ) begin
        in_pulse = 1'b0;
        in_guard = 1'b1;
        m_g      = 0;
      end else if (in_pulse) begin
        m_w++;
      end
      if (in_guard) begin
        if (bus.RSTBUSY) m_g++;
        else begin
          in_guard = 1'b0;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pulse actual=start@%0d required=none", m_start);
          end else begin
            e_mon = exp_q.pop_front();
            chk("pulse_start", m_start, e_mon.start);
            chk("pulse_width", m_w, e_mon.width);
            chk("guard_len", m_g, e_mon.guard);
            chk("pulse_cause", int'(m_cause), int'(e_mon.cause));
          end
        end
      end else if (!in_pulse && bus.RSTREQ) begin
        in_pulse = 1'b1;
        m_start  = edge_cnt - 1;
        m_w      = 1;
        m_cause  = bus.RSTCAUSE;
        chk("busy_at_rise", int'(bus.RSTBUSY), 1);
      end
    end
  end

  logic [4:0] stim [T];
  logic [2:0] src  [T];
  logic [3:0] lv;
  logic [3:0] mcause;
  int         avail, k, base, w, busy;
  bit         any_hi;

  initial begin
    drive(5'b0);
    RST = 1'b1;

    // Reset values, then software clear.
    tick(); tick();
    chk("rst_rstreq", int'(bus.RSTREQ), 0);
    chk("rst_busy", int'(bus.RSTBUSY), 0);
    chk("rst_cause", int'(bus.RSTCAUSE), 8);
    RST = 1'b0;
    bus.CAUSECLR = 1'b1;
    tick();
    bus.CAUSECLR = 1'b0;
    chk("causeclr", int'(bus.RSTCAUSE), 0);

    // Lockup only counts when enabled.
    bus.LOCKUP = 1'b1;
    any_hi = 1'b0;
    repeat (5) begin
      tick();
      if (bus.RSTREQ) any_hi = 1'b1;
    end
    chk("lockup_gated", int'(any_hi), 0);
    bus.LOCKUPRESET = 1'b1;
    tick();
    chk("lockup_rstreq", int'(bus.RSTREQ), 1);
    chk("lockup_cause", int'(bus.RSTCAUSE), 4);
    tick();
    chk("pulse_2nd_cycle", int'(bus.RSTREQ), 1);

    // Reset on the second pulse cycle aborts it; held request restarts a full pulse.
    RST = 1'b1;
    tick();
    chk("midrst_rstreq", int'(bus.RSTREQ), 0);
    chk("midrst_busy", int'(bus.RSTBUSY), 0);
    chk("midrst_cause", int'(bus.RSTCAUSE), 8);
    RST = 1'b0;
    tick();
    chk("restart_rstreq", int'(bus.RSTREQ), 1);
    chk("restart_cause", int'(bus.RSTCAUSE), 12);
    bus.LOCKUP      = 1'b0;
    bus.LOCKUPRESET = 1'b0;
    w    = 1;
    busy = 0;
    repeat (14) begin
      tick();
      if (bus.RSTREQ) w++;
      else if (bus.RSTBUSY) busy++;
    end
    chk("restart_width", w, P);
    chk("restart_guard", busy, G);
    chk("restart_idle", int'(bus.RSTBUSY), 0);

    // Clear and new event together: new bit kept, old bits cleared.
    bus.SYSRESETREQ = 1'b1;
    bus.CAUSECLR    = 1'b1;
    tick();
    bus.SYSRESETREQ = 1'b0;
    bus.CAUSECLR    = 1'b0;
    chk("clr_and_set_cause", int'(bus.RSTCAUSE), 1);
    chk("clr_and_set_rstreq", int'(bus.RSTREQ), 1);
    repeat (16) tick();

    // Random request waveforms: bursty levels, slow lockup enable, sparse clears.
    lv = 4'b0000;
    for (int n = 0; n < T; n++) begin
      if (n >= T - TAIL) stim[n] = 5'b0;
      else begin
        for (int b = 0; b < 3; b++) begin
          if (lv[b]) begin if ($urandom_range(3) == 0) lv[b] = 1'b0; end
          else       begin if ($urandom_range(19) == 0) lv[b] = 1'b1; end
        end
        if ($urandom_range(29) == 0) lv[3] = ~lv[3];
        stim[n] = {($urandom_range(24) == 0), lv};
      end
      src[n] = {stim[n][2] & stim[n][3], stim[n][1], stim[n][0]};
    end

    RST = 1'b1;
    tick(); tick();
    RST  = 1'b0;
    base = edge_cnt;

    // Timeline model: a pulse starts on the first request at or after the
    // accept point and lasts P cycles or until the first low at/after P.
    mcause = 4'b1000;
    avail  = 0;
    for (int n = 0; n < T; n++) begin
      if (stim[n][4]) mcause = 4'b0000;
      if (n >= avail && src[n] != 3'b000) begin
        mcause[2:0] = mcause[2:0] | src[n];
        k = n + P;
        while (k < T && src[k] != 3'b000) k++;
        exp_q.push_back('{base + n, k - n, G, mcause});
        avail = k + G + 1;
      end
    end

    mon_en = 1'b1;
    for (int n = 0; n < T; n++) begin
      drive(stim[n]);
      tick();
    end
    drive(5'b0);
    repeat (P + G + 10) tick();
    chk("queue_drained", exp_q.size(), 0);
    chk("final_cause", int'(bus.RSTCAUSE), int'(mcause));
    chk("final_idle", int'(bus.RSTBUSY), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
